// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch path: widths, major opcodes,
// instruction field positions and the buffered fetch entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam int unsigned OPC_LSB   = 0;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned FUNC3_LSB = 12;
  localparam int unsigned FUNC3_W   = 3;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS1_W     = 5;
  localparam int unsigned RS2_LSB   = 20;
  localparam int unsigned RS2_W     = 5;
  localparam int unsigned FUNC7_LSB = 25;
  localparam int unsigned FUNC7_W   = 7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundles around the fetch unit: instruction-memory port and the
// decode-side port (instruction hand-off plus redirect).
interface imem_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

interface decode_if;
  import riscv_pkg::*;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [ILEN-1:0]    id_instr;
  logic [XLEN-1:0]    id_pc;
  logic [OPC_W-1:0]   id_opcode;
  logic [FUNC3_W-1:0] id_func3;
  logic [FUNC7_W-1:0] id_func7;

  modport master (
    output id_valid, id_instr, id_pc, id_opcode, id_func3, id_func7,
    input  id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  id_valid, id_instr, id_pc, id_opcode, id_func3, id_func7,
    output id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush overrides
// push and pop, and a pop on a full FIFO frees room for a same-cycle push.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_c, do_pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited in-order memory
// requests, response buffering and redirect flushing toward decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input logic       clk,
  input logic       rst_n,
  imem_if.master    imem,
  decode_if.master  dec
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            run_q, run_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] redirect_pc_c;
  logic [OW-1:0]   occupancy_c;
  logic            req_valid_c, req_fire_c, rsp_fire_c;
  logic            keep_c, push_c, pop_c, redirect_c;
  fetch_entry_t    push_entry_c, head_entry_c;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Credits cover both in-flight and buffered words so the FIFO never overflows.
  assign occupancy_c  = {1'b0, infl_q} + {1'b0, fifo_count};
  assign req_valid_c  = run_q & (occupancy_c < OW'(DEPTH));
  assign req_fire_c   = req_valid_c & imem.imem_req_ready;
  assign rsp_fire_c   = imem.imem_rsp_valid;
  assign redirect_c   = dec.redirect_valid;
  assign redirect_pc_c = word_align(dec.redirect_pc);
  assign keep_c       = rsp_fire_c & (drop_q == '0);
  assign push_c       = keep_c & ~redirect_c;
  assign pop_c        = ~fifo_empty & dec.id_ready;

  assign push_entry_c.pc    = rsp_pc_q;
  assign push_entry_c.instr = imem.imem_rsp_data;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .flush     (redirect_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_entry_c)
  );

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    run_d    = 1'b1;
    infl_d   = infl_q + CW'(req_fire_c) - CW'(rsp_fire_c);
    drop_d   = drop_q;
    if (redirect_c) begin
      // Everything still in flight after this edge is stale, including this cycle's request.
      pc_d     = redirect_pc_c;
      rsp_pc_d = redirect_pc_c;
      drop_d   = infl_d;
    end else begin
      if (req_fire_c)                    pc_d     = pc_q + XLEN'(4);
      if (keep_c)                        rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_fire_c && drop_q != '0)    drop_d   = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      run_q    <= 1'b0;
      infl_q   <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      run_q    <= run_d;
      infl_q   <= infl_d;
      drop_q   <= drop_d;
    end
  end

  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_req_addr  = word_align(pc_q);

  assign dec.id_valid  = ~fifo_empty;
  assign dec.id_instr  = head_entry_c.instr;
  assign dec.id_pc     = head_entry_c.pc;
  assign dec.id_opcode = head_entry_c.instr[OPC_LSB   +: OPC_W];
  assign dec.id_func3  = head_entry_c.instr[FUNC3_LSB +: FUNC3_W];
  assign dec.id_func7  = head_entry_c.instr[FUNC7_LSB +: FUNC7_W];

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && fifo_full && !pop_c));

endmodule
